key_matrix_scanner: RTL and testbench
=====================================

KEY_MATRIX_SCANNER -- requirements
Module: key_matrix_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 1024: clock cycles each column is driven (dwell); legal range 4..65535.
REQ-002 Parameter DEBOUNCE_FRAMES, default 4: consecutive identical frames required to accept a press or a release; legal range 1..15.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 col_sel  output  4  column drive to keypad, active-low one-hot (0 = column driven).
REQ-006 row_in  input  4  keypad rows, active-low (0 = key closed), asynchronous to clk.
REQ-007 key_code  output  4  accepted key index = col*4 + row.
REQ-008 key_valid  output  1  key_code holds an unconsumed key.
REQ-009 key_ack  input  1  consumer accepts key_code this cycle.
REQ-010 overflow  output  1  sticky: at least one key was dropped since the last accepted ack.

Function
REQ-011 row_in SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value only.
REQ-012 col_sel SHALL cycle 1110 -> 1101 -> 1011 -> 0111 -> 1110, each value held exactly SCAN_DIV cycles; one frame = 4*SCAN_DIV cycles.
REQ-013 Rows SHALL be sampled on the last cycle of each column dwell only (settling margin).
REQ-014 At frame end the frame result SHALL be the lowest pressed index, or "none"; multiple simultaneous keys resolve to the lowest index.
REQ-015 FSM states: IDLE, CONFIRM, HOLD, RELEASE.
REQ-016 IDLE: frame result is a key -> capture candidate, count = 1, go CONFIRM (or accept immediately if DEBOUNCE_FRAMES = 1).
REQ-017 CONFIRM: frame result equals candidate -> count+1; count reaches DEBOUNCE_FRAMES -> accept, go HOLD; any other result -> IDLE, count cleared.
REQ-018 HOLD: frame result "none" -> go RELEASE, count = 1; any key result -> stay HOLD (no auto-repeat; a second key while the first is held is ignored).
REQ-019 RELEASE: "none" -> count+1, reaching DEBOUNCE_FRAMES -> IDLE; any key -> back to HOLD.
REQ-020 Accept: if key_valid = 0, key_code <= candidate and key_valid <= 1 on the following cycle.
REQ-021 key_ack with key_valid = 1 SHALL clear key_valid on the next cycle and clear overflow; key_ack with key_valid = 0 has no effect.
REQ-022 Accept while key_valid = 1 and no key_ack the same cycle: key_code unchanged, overflow <= 1.
REQ-023 Accept and key_ack in the same cycle: new key loads, key_valid stays 1, overflow <= 0.
REQ-024 key_code SHALL remain stable while key_valid = 1.
REQ-025 Latency: key_valid rises exactly 1 cycle after the frame-end cycle that completes debounce.

Reset
REQ-026 reset = 0 at a clock edge: col_sel = 1110, dwell counter = 0, column = 0, FSM = IDLE, count = 0, key_code = 0, key_valid = 0, overflow = 0, synchronizer flops = 1111.
REQ-027 Reset asserted mid-frame or mid-debounce SHALL discard any candidate and pending key; scanning restarts at column 0 on the first cycle after reset = 1.

Structure
REQ-028 Shared package SHALL hold the FSM state encoding, column count (4), row count (4) and key_code width (4).
REQ-029 Debounce FSM plus output buffer SHALL live in one sub-module, key_debounce; the column counter, synchronizer and priority encoder stay in key_matrix_scanner.

Verification (SCAN_DIV = 4, DEBOUNCE_FRAMES = 2, frame = 16 cycles)
REQ-030 Reset, then no keys for 64 cycles -> col_sel sequence 1110, 1101, 1011, 0111 with 4 cycles each; key_valid = 0 and overflow = 0 throughout.
REQ-031 Hold row 2 low during column 1 for 2 frames -> key_valid = 1 and key_code = 6, one cycle after the second frame end; holding for 1 frame only -> no key_valid.
REQ-032 Keys 9 and 3 held together -> key_code = 3; holding key 3 for 10 frames -> exactly one accept; release for 2 frames, then press key 3 again for 2 frames -> second accept.
REQ-033 Key 5 accepted, no ack, then key 7 accepted -> key_code stays 5 and overflow = 1; key_ack -> key_valid = 0 and overflow = 0 on the next cycle.
REQ-034 Accept of key 12 in the same cycle as key_ack of key 4 -> key_code = 12, key_valid stays 1, overflow = 0.
REQ-035 reset = 0 during the CONFIRM state with key 1 held -> all outputs at reset values; after reset = 1 with key 1 still held -> accept after 2 full frames from column 0.

Source files
------------

// File: rtl/key_matrix_scanner_pkg.sv
// Shared definitions for the key matrix scanner: matrix geometry, key code width,
// debounce state encoding and the row priority helper.
package key_matrix_scanner_pkg;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;
  localparam int KEY_W    = 4;
  localparam int COL_W    = 2;
  localparam int ROW_W    = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONFIRM = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } debounce_state_t;

  // Index of the lowest active row; callers only use it when some row is active.
  function automatic logic [ROW_W-1:0] lowestRow(input logic [NUM_ROWS-1:0] active);
    lowestRow = '0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (active[i]) lowestRow = ROW_W'(i);
    end
  endfunction

endpackage

// File: rtl/key_matrix_scanner_debounce.sv
// Frame-level debounce FSM for the key scanner plus the single-entry key buffer
// with sticky overflow reporting.
module key_debounce
  import key_matrix_scanner_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_frameEnd,
  input  logic             i_frameHit,
  input  logic [KEY_W-1:0] i_frameKey,
  input  logic             i_keyAck,
  output logic [KEY_W-1:0] o_keyCode,
  output logic             o_keyValid,
  output logic             o_overflow
);

  localparam logic [4:0] DF_TARGET    = 5'(DEBOUNCE_FRAMES);
  localparam bit         SINGLE_FRAME = (DEBOUNCE_FRAMES == 1);

  debounce_state_t  r_state, w_nextState;
  logic [3:0]       r_count, w_nextCount;
  logic [KEY_W-1:0] r_cand, w_nextCand;
  logic [4:0]       w_countInc;
  logic             w_accept;

  logic [KEY_W-1:0] r_keyCode;
  logic             r_keyValid;
  logic             r_overflow;

  assign w_countInc = {1'b0, r_count} + 5'd1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_count <= '0;
      r_cand  <= '0;
    end else begin
      r_state <= w_nextState;
      r_count <= w_nextCount;
      r_cand  <= w_nextCand;
    end
  end

  // The FSM only moves on frame-end cycles; every other cycle holds state.
  always_comb begin
    w_nextState = r_state;
    w_nextCount = r_count;
    w_nextCand  = r_cand;
    if (i_frameEnd) begin
      case (r_state)
        IDLE: begin
          if (i_frameHit) begin
            w_nextCand = i_frameKey;
            if (SINGLE_FRAME) begin
              w_nextState = HOLD;
              w_nextCount = '0;
            end else begin
              w_nextState = CONFIRM;
              w_nextCount = 4'd1;
            end
          end
        end
        CONFIRM: begin
          if (i_frameHit && (i_frameKey == r_cand)) begin
            if (w_countInc == DF_TARGET) begin
              w_nextState = HOLD;
              w_nextCount = '0;
            end else begin
              w_nextCount = w_countInc[3:0];
            end
          end else begin
            w_nextState = IDLE;
            w_nextCount = '0;
          end
        end
        HOLD: begin
          if (!i_frameHit) begin
            if (SINGLE_FRAME) begin
              w_nextState = IDLE;
              w_nextCount = '0;
            end else begin
              w_nextState = RELEASE;
              w_nextCount = 4'd1;
            end
          end
        end
        RELEASE: begin
          if (i_frameHit) begin
            w_nextState = HOLD;
            w_nextCount = '0;
          end else if (w_countInc == DF_TARGET) begin
            w_nextState = IDLE;
            w_nextCount = '0;
          end else begin
            w_nextCount = w_countInc[3:0];
          end
        end
        default: begin
          w_nextState = IDLE;
          w_nextCount = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_accept = 1'b0;
    if (i_frameEnd && i_frameHit) begin
      if (r_state == IDLE && SINGLE_FRAME) begin
        w_accept = 1'b1;
      end else if (r_state == CONFIRM && i_frameKey == r_cand && w_countInc == DF_TARGET) begin
        w_accept = 1'b1;
      end
    end
  end

  // A full buffer without an ack in the same cycle drops the new key and flags it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_keyCode  <= '0;
      r_keyValid <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_accept) begin
      if (!r_keyValid || i_keyAck) begin
        r_keyCode  <= i_frameKey;
        r_keyValid <= 1'b1;
        if (r_keyValid) r_overflow <= 1'b0;
      end else begin
        r_overflow <= 1'b1;
      end
    end else if (i_keyAck && r_keyValid) begin
      r_keyValid <= 1'b0;
      r_overflow <= 1'b0;
    end
  end

  assign o_keyCode  = r_keyCode;
  assign o_keyValid = r_keyValid;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/key_matrix_scanner.sv
// 4x4 keypad scanner: drives columns, synchronizes rows, reduces each frame to the
// lowest pressed key and hands the frame result to the debounce block.
module key_matrix_scanner
  import key_matrix_scanner_pkg::*;
#(
  parameter int SCAN_DIV        = 1024,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic                clk,
  input  logic                reset,
  output logic [NUM_COLS-1:0] col_sel,
  input  logic [NUM_ROWS-1:0] row_in,
  output logic [KEY_W-1:0]    key_code,
  output logic                key_valid,
  input  logic                key_ack,
  output logic                overflow
);

  localparam logic [15:0]      DWELL_LAST = 16'(SCAN_DIV - 1);
  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(NUM_COLS - 1);

  logic [NUM_ROWS-1:0] r_rowSync1, r_rowSync2;
  logic [15:0]         r_dwellCnt;
  logic [COL_W-1:0]    r_col;
  logic                r_hitFound;
  logic [KEY_W-1:0]    r_hitKey;

  logic                w_dwellEnd;
  logic                w_frameEnd;
  logic [NUM_ROWS-1:0] w_rowsLow;
  logic                w_colHit;
  logic [KEY_W-1:0]    w_colKey;
  logic                w_frameHit;
  logic [KEY_W-1:0]    w_frameKey;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rowSync1 <= '1;
      r_rowSync2 <= '1;
    end else begin
      r_rowSync1 <= row_in;
      r_rowSync2 <= r_rowSync1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_dwellCnt <= '0;
      r_col      <= '0;
    end else if (w_dwellEnd) begin
      r_dwellCnt <= '0;
      r_col      <= r_col + COL_W'(1);
    end else begin
      r_dwellCnt <= r_dwellCnt + 16'd1;
    end
  end

  assign col_sel    = ~(NUM_COLS'(1) << r_col);
  assign w_dwellEnd = (r_dwellCnt == DWELL_LAST);
  assign w_frameEnd = w_dwellEnd && (r_col == COL_LAST);
  assign w_rowsLow  = ~r_rowSync2;
  assign w_colHit   = |w_rowsLow;
  assign w_colKey   = {r_col, lowestRow(w_rowsLow)};

  // Columns are scanned in ascending order, so the first hit in a frame is the lowest key.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hitFound <= 1'b0;
      r_hitKey   <= '0;
    end else if (w_frameEnd) begin
      r_hitFound <= 1'b0;
      r_hitKey   <= '0;
    end else if (w_dwellEnd && w_colHit && !r_hitFound) begin
      r_hitFound <= 1'b1;
      r_hitKey   <= w_colKey;
    end
  end

  assign w_frameHit = w_dwellEnd && (r_hitFound || w_colHit);
  assign w_frameKey = r_hitFound ? r_hitKey : w_colKey;

  key_debounce #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_debounce (
    .clk       (clk),
    .reset     (reset),
    .i_frameEnd(w_frameEnd),
    .i_frameHit(w_frameHit),
    .i_frameKey(w_frameKey),
    .i_keyAck  (key_ack),
    .o_keyCode (key_code),
    .o_keyValid(key_valid),
    .o_overflow(overflow)
  );

endmodule

// File: tb/tb_key_matrix_scanner.sv
// Directed bench for key_matrix_scanner with a small keypad model (SCAN_DIV=4,
// DEBOUNCE_FRAMES=2, 16-cycle frames); expected values are hand-derived cycle counts.
module tb_key_matrix_scanner;

  logic        clk;
  logic        reset;
  logic [3:0]  col_sel;
  logic [3:0]  row_in;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ack;
  logic        overflow;

  logic [15:0] pressed;
  int          edgeCnt;
  int          checkCount;
  int          errorCount;

  key_matrix_scanner #(
    .SCAN_DIV       (4),
    .DEBOUNCE_FRAMES(2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .col_sel  (col_sel),
    .row_in   (row_in),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_ack  (key_ack),
    .overflow (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // A closed key pulls its row low while its column is driven.
  always_comb begin
    row_in = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (pressed[c*4 + r] && !col_sel[c]) row_in[r] = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", tag, actual, expected, edgeCnt);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] keys);
    pressed = keys;
  endtask

  task automatic stepEdges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
    edgeCnt += n;
  endtask

  task automatic resetDut();
    reset = 1'b0;
    stepEdges(2);
    checkOutput("rstColSel", 16'(col_sel), 16'hE);
    checkOutput("rstKeyCode", 16'(key_code), 16'h0);
    checkOutput("rstKeyValid", 16'(key_valid), 16'h0);
    checkOutput("rstOverflow", 16'(overflow), 16'h0);
    reset = 1'b1;
    edgeCnt = 0;
  endtask

  initial begin
    logic [3:0] expCol;
    logic       seen;
    int         validCycles;

    checkCount = 0;
    errorCount = 0;
    edgeCnt    = 0;
    reset      = 1'b0;
    key_ack    = 1'b0;
    pressed    = '0;
    @(negedge clk);

    // Idle scanning: column walk and quiet outputs
    resetDut();
    seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      expCol = ~(4'b0001 << ((i % 16) / 4));
      checkOutput("colWalk", 16'(col_sel), 16'(expCol));
      seen = seen | key_valid | overflow;
      stepEdges(1);
    end
    checkOutput("idleQuiet", 16'(seen), 16'h0);

    // Key 6 held for a single frame is not accepted
    resetDut();
    applyStimulus(16'h0001 << 6);
    stepEdges(16);
    applyStimulus('0);
    stepEdges(48);
    checkOutput("oneFrameNoKey", 16'(key_valid), 16'h0);

    // Key 6 held for two frames: valid exactly after the second frame end
    resetDut();
    applyStimulus(16'h0001 << 6);
    stepEdges(31);
    checkOutput("key6Early", 16'(key_valid), 16'h0);
    stepEdges(1);
    checkOutput("key6Valid", 16'(key_valid), 16'h1);
    checkOutput("key6Code", 16'(key_code), 16'h6);
    key_ack = 1'b1;
    stepEdges(1);
    key_ack = 1'b0;
    checkOutput("key6Acked", 16'(key_valid), 16'h0);
    applyStimulus('0);

    // Keys 9 and 3 together resolve to 3; long hold gives one accept
    resetDut();
    applyStimulus((16'h0001 << 9) | (16'h0001 << 3));
    stepEdges(32);
    checkOutput("lowestValid", 16'(key_valid), 16'h1);
    checkOutput("lowestCode", 16'(key_code), 16'h3);
    applyStimulus(16'h0001 << 3);
    key_ack = 1'b1;
    stepEdges(1);
    key_ack = 1'b0;
    validCycles = 0;
    while (edgeCnt < 160) begin
      if (key_valid) validCycles++;
      stepEdges(1);
    end
    checkOutput("noRepeat", 16'(validCycles), 16'h0);
    applyStimulus('0);
    stepEdges(32);
    applyStimulus(16'h0001 << 3);
    stepEdges(31);
    checkOutput("repressEarly", 16'(key_valid), 16'h0);
    stepEdges(1);
    checkOutput("repressValid", 16'(key_valid), 16'h1);
    checkOutput("repressCode", 16'(key_code), 16'h3);
    applyStimulus('0);

    // Key 5 unacked, then key 7 accepted: dropped with overflow
    resetDut();
    applyStimulus(16'h0001 << 5);
    stepEdges(32);
    checkOutput("key5Code", 16'(key_code), 16'h5);
    applyStimulus('0);
    stepEdges(32);
    applyStimulus(16'h0001 << 7);
    stepEdges(31);
    checkOutput("ovfBefore", 16'(overflow), 16'h0);
    stepEdges(1);
    checkOutput("ovfValid", 16'(key_valid), 16'h1);
    checkOutput("ovfCodeKept", 16'(key_code), 16'h5);
    checkOutput("ovfSet", 16'(overflow), 16'h1);
    key_ack = 1'b1;
    stepEdges(1);
    key_ack = 1'b0;
    checkOutput("ackClrValid", 16'(key_valid), 16'h0);
    checkOutput("ackClrOvf", 16'(overflow), 16'h0);
    applyStimulus('0);

    // Key 12 accepted in the same cycle key 4 is acked
    resetDut();
    applyStimulus(16'h0001 << 4);
    stepEdges(32);
    checkOutput("key4Code", 16'(key_code), 16'h4);
    applyStimulus('0);
    stepEdges(32);
    applyStimulus(16'h0001 << 12);
    stepEdges(31);
    key_ack = 1'b1;
    stepEdges(1);
    key_ack = 1'b0;
    checkOutput("sameCycValid", 16'(key_valid), 16'h1);
    checkOutput("sameCycCode", 16'(key_code), 16'hC);
    checkOutput("sameCycOvf", 16'(overflow), 16'h0);
    applyStimulus('0);

    // Reset in CONFIRM with key 1 held: candidate discarded, scan restarts
    resetDut();
    applyStimulus(16'h0001 << 1);
    stepEdges(20);
    reset = 1'b0;
    stepEdges(1);
    checkOutput("midRstColSel", 16'(col_sel), 16'hE);
    checkOutput("midRstValid", 16'(key_valid), 16'h0);
    checkOutput("midRstCode", 16'(key_code), 16'h0);
    checkOutput("midRstOvf", 16'(overflow), 16'h0);
    reset = 1'b1;
    edgeCnt = 0;
    stepEdges(31);
    checkOutput("postRstEarly", 16'(key_valid), 16'h0);
    stepEdges(1);
    checkOutput("postRstValid", 16'(key_valid), 16'h1);
    checkOutput("postRstCode", 16'(key_code), 16'h1);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
